// File: rtl/prbs_checker.sv
// prbs_checker
//   Receive-side checker for the 32-bit Fibonacci LFSR generator.
//   It self-seeds a local LFSR from the incoming stream. It declares lock after
//   LOCK_MATCHES consecutive correct predictions. While locked it free-runs the
//   local LFSR, flags and counts bit errors, and drops lock when a window of
//   WINDOW accepted bits collects UNLOCK_ERRORS errors.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   ce         in   bit-valid strobe; din is sampled only when ce=1
//   din        in   received serial bit (generator's new feedback bit)
//   resync     in   return to seeding; err_count/bit_count are kept
//   clr_count  in   clear err_count and bit_count
//   locked     out  1 while in the locked state
//   err        out  one-cycle pulse per mismatched bit while locked
//   err_count  out  saturating error count while locked
//   bit_count  out  saturating checked-bit count while locked

module prbs_checker #(
    parameter int LOCK_MATCHES  = 64,
    parameter int UNLOCK_ERRORS = 8,
    parameter int WINDOW        = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        din,
    input  logic        resync,
    input  logic        clr_count,
    output logic        locked,
    output logic        err,
    output logic [31:0] err_count,
    output logic [31:0] bit_count
);

    // Taps 31,29,28,27,23,20,19,17,15,14,12,11,9,4,3,2
    localparam logic [31:0] TAP_MASK = 32'hB89A_DA1C;

    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(UNLOCK_ERRORS + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_ERRORS - 1);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]    state;
    logic [31:0]   s;
    logic [4:0]    seed_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    logic pred;
    logic mismatch;
    logic s_zero;

    always_comb begin
        pred     = ^(s & TAP_MASK);
        mismatch = din ^ pred;
        s_zero   = (s == '0);
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SEED;
            s         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else if (resync) begin
            state     <= ST_SEED;
            s         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (ce) begin
                case (state)
                    ST_SEED: begin
                        s <= {s[30:0], din};
                        if (seed_cnt == 5'd31) begin
                            state    <= ST_SYNC;
                            seed_cnt <= '0;
                        end else begin
                            seed_cnt <= seed_cnt + 5'd1;
                        end
                    end
                    ST_SYNC: begin
                        s <= {s[30:0], din};
                        // An all-zero register predicts zeros forever, so a
                        // match there proves nothing and restarts the run.
                        if (!mismatch && !s_zero) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= ST_LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                win_cnt   <= '0;
                                win_err   <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run on the prediction so line errors stay isolated.
                        s   <= {s[30:0], pred};
                        err <= mismatch;
                        if (mismatch && (win_err == ERR_LAST)) begin
                            state     <= ST_SEED;
                            locked    <= 1'b0;
                            s         <= '0;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            if (mismatch) begin
                                win_err <= win_err + EW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_SEED;
                    end
                endcase
            end

            // Clearing wins over a same-cycle count; err above is unaffected.
            if (clr_count) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (ce && (state == ST_LOCKED)) begin
                bit_count <= sat_inc(bit_count);
                if (mismatch) begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule
